reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-back stage of the 8-bit datapath, at the opposite end of the operand-select path.
- Takes one result per accepted request (ALU, immediate or memory read data) and routes it to register A, register B, or a buffered memory write port.
- Holds registers A/B, which feed the operand muxes, and the Z/N/C status flags.
- Small FSM plus a one-entry buffer that decouples a slow memory write from the control unit.

Parameters:
- WIDTH, 8, datapath width in bits.
- RESET_A, 0, value of register A after reset.
- RESET_B, 0, value of register B after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wrEn  input  1  write request from control unit.
- dst  input  2  destination: 00 none, 01 reg A, 10 reg B, 11 memory.
- srcSel  input  2  source: 00 aluResult, 01 dataIM, 10 memRdata, 11 dataRegB (move B).
- aluResult  input  WIDTH  ALU output.
- aluCarry  input  1  ALU carry out.
- dataIM  input  WIDTH  immediate from instruction memory.
- memRdata  input  WIDTH  data memory read data.
- dataRegA  output  WIDTH  register A contents.
- dataRegB  output  WIDTH  register B contents.
- memWdata  output  WIDTH  buffered memory write data.
- memWvalid  output  1  memory write pending.
- memWready  input  1  memory accepts write this cycle.
- busy  output  1  request cannot be accepted this cycle.
- flagZ, flagN, flagC  output  1 each  status flags.

Behaviour:
- Clocking: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: dataRegA=RESET_A, dataRegB=RESET_B, memWdata=0, memWvalid=0, flags=0, FSM=IDLE.
- A reset mid-memory-write drops the pending write.
- Source mux is combinational: src = aluResult/dataIM/memRdata/dataRegB per srcSel.
- Acceptance: request is accepted when wrEn=1 and busy=0.
- busy = memWvalid & ~memWready (combinational); allows back-to-back memory writes in the cycle the buffer drains.
- Requester holds wrEn, dst and srcSel stable while busy=1.
- Register write (dst=01/10), accepted at edge N: register updated at edge N, visible after it. Latency 1 cycle, no effect on FSM.
- dst=00 with wrEn: no state change. Flags are not updated.
- Flags update only on an accepted register write with srcSel=00:
  - flagZ = (aluResult==0)
  - flagN = aluResult[WIDTH-1]
  - flagC = aluCarry
- Any other source leaves the flags unchanged.
- FSM states: IDLE, MEMW.
  - IDLE: accepted dst=11 -> memWdata<=src, memWvalid<=1, go to MEMW.
  - MEMW: memWvalid=1 and memWdata held stable until memWready=1.
  - MEMW, memWready=1 with no new dst=11 accepted -> memWvalid<=0, go to IDLE.
  - MEMW, memWready=1 with a simultaneous accepted dst=11 -> load new data, stay in MEMW, memWvalid stays 1.
- Register writes are accepted in MEMW whenever busy=0; while busy=1 all requests stall, including register writes (in-order write-back).
- srcSel=11 with dst=10 (B<=B) is legal and leaves B unchanged.
- Values wrap modulo 2^WIDTH; no width extension is performed.

Decomposition:
- Shared package/header reg_wb_defs: DST_NONE/DST_A/DST_B/DST_MEM codes, SRC_ALU/SRC_IM/SRC_MEM/SRC_REGB codes, FSM state encodings IDLE=0, MEMW=1.
- One natural sub-module: wb_src_mux, the 4:1 combinational source select, reusable alongside the operand mux.
- Registers, flags and FSM stay in the top.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> dataRegA=0, dataRegB=0, memWvalid=0, flags=000 immediately, without waiting for a clock edge.
- ALU to A: wrEn, dst=01, srcSel=00, aluResult=0x80, aluCarry=1 -> next cycle dataRegA=0x80, flagZ=0, flagN=1, flagC=1; dataRegB unchanged.
- Immediate to B with flags held: prior flags Z=1; wrEn, dst=10, srcSel=01, dataIM=0x00 -> dataRegB=0x00, flagZ stays 1, flagN and flagC unchanged.
- Memory write stall: dst=11, srcSel=11, dataRegB=0x5A, memWready=0 for 3 cycles -> memWvalid=1, memWdata=0x5A held, busy=1. A register write request held during the stall is not applied until memWready=1.
- Back-to-back memory writes: memWvalid=1, memWready=1 and new accepted dst=11 with dataIM=0x33 in the same cycle -> memWvalid stays 1, memWdata=0x33 next cycle, FSM stays in MEMW.
- Reset during MEMW: memWvalid=1, assert rst -> memWvalid=0, FSM=IDLE; the pending write is never re-issued after reset deasserts.

Source files
------------

// File: rtl/reg_wb_defs_pkg.sv
// Shared encodings for the write-back stage: destination and source selects
// plus the memory-write FSM states.
package reg_wb_defs;

  localparam logic [1:0] DST_NONE = 2'b00;
  localparam logic [1:0] DST_A    = 2'b01;
  localparam logic [1:0] DST_B    = 2'b10;
  localparam logic [1:0] DST_MEM  = 2'b11;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_IM   = 2'b01;
  localparam logic [1:0] SRC_MEM  = 2'b10;
  localparam logic [1:0] SRC_REGB = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MEMW = 1'b1
  } wbState_t;

endpackage

// File: rtl/wb_src_mux.sv
// 4:1 combinational source select for the write-back result; shaped like the
// operand mux so both can be reused side by side.
module wb_src_mux
  import reg_wb_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       srcSel,
  input  logic [WIDTH-1:0] aluResult,
  input  logic [WIDTH-1:0] dataIM,
  input  logic [WIDTH-1:0] memRdata,
  input  logic [WIDTH-1:0] dataRegB,
  output logic [WIDTH-1:0] src
);

  always_comb begin
    // NOTE: every path assigns src (default first) so no latch is inferred.
    src = aluResult;
    case (srcSel)
      SRC_ALU:  src = aluResult;
      SRC_IM:   src = dataIM;
      SRC_MEM:  src = memRdata;
      SRC_REGB: src = dataRegB;
      default:  src = aluResult;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: routes one selected result per accepted request into
// register A, register B or a one-entry buffered memory write port.
module reg_writeback
  import reg_wb_defs::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_A = '0,
  parameter logic [WIDTH-1:0] RESET_B = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [1:0]       dst,
  input  logic [1:0]       srcSel,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarry,
  input  logic [WIDTH-1:0] dataIM,
  input  logic [WIDTH-1:0] memRdata,
  output logic [WIDTH-1:0] dataRegA,
  output logic [WIDTH-1:0] dataRegB,
  output logic [WIDTH-1:0] memWdata,
  output logic             memWvalid,
  input  logic             memWready,
  output logic             busy,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagC
);

  wbState_t         state;
  wbState_t         stateNext;
  logic [WIDTH-1:0] src;
  logic             accept;
  logic             memAccept;
  logic             regAccept;
  logic             flagLoad;

  wb_src_mux #(.WIDTH(WIDTH)) uSrcMux (
    .srcSel    (srcSel),
    .aluResult (aluResult),
    .dataIM    (dataIM),
    .memRdata  (memRdata),
    .dataRegB  (dataRegB),
    .src       (src)
  );

  // The buffer is full exactly while in MEMW; it frees up in the cycle the
  // memory takes the data, which is what permits back-to-back writes.
  assign memWvalid = (state == MEMW);
  assign busy      = memWvalid & ~memWready;
  assign accept    = wrEn & ~busy;
  assign memAccept = accept & (dst == DST_MEM);
  assign regAccept = accept & ((dst == DST_A) | (dst == DST_B));
  assign flagLoad  = regAccept & (srcSel == SRC_ALU);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memAccept) stateNext = MEMW;
      MEMW:    if (memWready && !memAccept) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A memAccept only happens when the buffer is empty or draining, so the
  // held data is never overwritten before the memory has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            memWdata <= '0;
    else if (memAccept) memWdata <= src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataRegA <= RESET_A;
      dataRegB <= RESET_B;
    end else begin
      if (accept && dst == DST_A) dataRegA <= src;
      if (accept && dst == DST_B) dataRegB <= src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagZ <= 1'b0;
      flagN <= 1'b0;
      flagC <= 1'b0;
    end else if (flagLoad) begin
      flagZ <= (aluResult == '0);
      flagN <= aluResult[WIDTH-1];
      flagC <= aluCarry;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: register/flag model checked inline
// per scenario, memory writes checked through an expected-data queue.
module tb_reg_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrEn;
  logic [1:0] dst;
  logic [1:0] srcSel;
  logic [7:0] aluResult;
  logic       aluCarry;
  logic [7:0] dataIM;
  logic [7:0] memRdata;
  logic [7:0] dataRegA;
  logic [7:0] dataRegB;
  logic [7:0] memWdata;
  logic       memWvalid;
  logic       memWready;
  logic       busy;
  logic       flagZ;
  logic       flagN;
  logic       flagC;

  int         nAsserts = 0;
  int         nFails   = 0;
  logic [7:0] expQ[$];
  logic [7:0] mA, mB;
  logic       mZ, mN, mC;

  always #5 clk = ~clk;

  reg_writeback #(.WIDTH(8), .RESET_A(8'h00), .RESET_B(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .wrEn      (wrEn),
    .dst       (dst),
    .srcSel    (srcSel),
    .aluResult (aluResult),
    .aluCarry  (aluCarry),
    .dataIM    (dataIM),
    .memRdata  (memRdata),
    .dataRegA  (dataRegA),
    .dataRegB  (dataRegB),
    .memWdata  (memWdata),
    .memWvalid (memWvalid),
    .memWready (memWready),
    .busy      (busy),
    .flagZ     (flagZ),
    .flagN     (flagN),
    .flagC     (flagC)
  );

  // Inputs only change at posedge+1, so the negedge sees a settled handshake.
  always @(negedge clk) begin
    if (!rst && memWvalid && memWready) begin
      nAsserts++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("FAIL mem_unexpected: got write %h, required none", memWdata);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        if (memWdata !== e) begin
          nFails++;
          $display("FAIL mem_data: got %h, required %h", memWdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wrEn = 1'b0; dst = 2'b00; srcSel = 2'b00;
    aluResult = 8'h00; aluCarry = 1'b0; dataIM = 8'h00; memRdata = 8'h00;
  endtask

  task automatic test_reset();
    idleInputs();
    memWready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mA = 8'h00; mB = 8'h00; mZ = 1'b0; mN = 1'b0; mC = 1'b0;
    #1;
    nAsserts++;
    if ({dataRegA, dataRegB} !== 16'h0000) begin
      nFails++; $display("FAIL reset_regs: got %h/%h, required 00/00", dataRegA, dataRegB);
    end
    nAsserts++;
    if ({memWvalid, busy, flagZ, flagN, flagC} !== 5'b00000) begin
      nFails++; $display("FAIL reset_ctl: got %b, required 00000", {memWvalid, busy, flagZ, flagN, flagC});
    end
  endtask

  task automatic test_alu_to_a();
    wrEn = 1'b1; dst = 2'b01; srcSel = 2'b00; aluResult = 8'h80; aluCarry = 1'b1;
    tick();
    idleInputs();
    mA = 8'h80; mZ = 1'b0; mN = 1'b1; mC = 1'b1;
    nAsserts++;
    if (dataRegA !== mA || dataRegB !== mB) begin
      nFails++; $display("FAIL alu_to_a regs: got %h/%h, required %h/%h", dataRegA, dataRegB, mA, mB);
    end
    nAsserts++;
    if ({flagZ, flagN, flagC} !== {mZ, mN, mC}) begin
      nFails++; $display("FAIL alu_to_a flags: got %b, required %b", {flagZ, flagN, flagC}, {mZ, mN, mC});
    end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    nAsserts++;
    if ({dataRegA, dataRegB, memWvalid, flagZ, flagN, flagC} !== 20'h0_0000) begin
      nFails++;
      $display("FAIL async_reset: got A=%h B=%h v=%b f=%b, required all zero",
               dataRegA, dataRegB, memWvalid, {flagZ, flagN, flagC});
    end
    tick();
    rst = 1'b0;
    mA = 8'h00; mB = 8'h00; mZ = 1'b0; mN = 1'b0; mC = 1'b0;
  endtask

  task automatic test_imm_to_b();
    // ALU zero result into A sets Z=1, N=0, C=0.
    wrEn = 1'b1; dst = 2'b01; srcSel = 2'b00; aluResult = 8'h00; aluCarry = 1'b0;
    tick();
    mA = 8'h00; mZ = 1'b1; mN = 1'b0; mC = 1'b0;
    nAsserts++;
    if ({flagZ, flagN, flagC} !== 3'b100) begin
      nFails++; $display("FAIL zero_flags: got %b, required 100", {flagZ, flagN, flagC});
    end
    // Immediate 0x00 into B with a misleading ALU value: flags must hold.
    dst = 2'b10; srcSel = 2'b01; dataIM = 8'h00; aluResult = 8'hFF; aluCarry = 1'b1;
    tick();
    mB = 8'h00;
    nAsserts++;
    if (dataRegB !== mB || {flagZ, flagN, flagC} !== {mZ, mN, mC}) begin
      nFails++; $display("FAIL imm_to_b: got B=%h f=%b, required B=%h f=%b",
                         dataRegB, {flagZ, flagN, flagC}, mB, {mZ, mN, mC});
    end
    dataIM = 8'h5A;
    tick();
    mB = 8'h5A;
    // memRdata into A.
    dst = 2'b01; srcSel = 2'b10; memRdata = 8'hC7;
    tick();
    mA = 8'hC7;
    nAsserts++;
    if (dataRegA !== mA || dataRegB !== mB) begin
      nFails++; $display("FAIL mem_to_a: got %h/%h, required %h/%h", dataRegA, dataRegB, mA, mB);
    end
    // B -> B leaves B unchanged, then B -> A moves it.
    dst = 2'b10; srcSel = 2'b11;
    tick();
    dst = 2'b01; srcSel = 2'b11;
    tick();
    mA = mB;
    nAsserts++;
    if (dataRegA !== mA || dataRegB !== mB || {flagZ, flagN, flagC} !== {mZ, mN, mC}) begin
      nFails++; $display("FAIL move_b: got %h/%h f=%b, required %h/%h f=%b", dataRegA, dataRegB,
                         {flagZ, flagN, flagC}, mA, mB, {mZ, mN, mC});
    end
    // dst none with an ALU source changes nothing, flags included.
    dst = 2'b00; srcSel = 2'b00; aluResult = 8'h81; aluCarry = 1'b1;
    tick();
    idleInputs();
    nAsserts++;
    if (dataRegA !== mA || dataRegB !== mB || {flagZ, flagN, flagC} !== {mZ, mN, mC} || memWvalid !== 1'b0) begin
      nFails++; $display("FAIL dst_none: got %h/%h f=%b v=%b, required %h/%h f=%b v=0", dataRegA, dataRegB,
                         {flagZ, flagN, flagC}, memWvalid, mA, mB, {mZ, mN, mC});
    end
  endtask

  task automatic test_mem_stall();
    memWready = 1'b0;
    wrEn = 1'b1; dst = 2'b11; srcSel = 2'b11;
    expQ.push_back(mB);
    tick();
    // Held register write request while the buffer is stalled.
    dst = 2'b01; srcSel = 2'b01; dataIM = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      nAsserts++;
      if ({memWvalid, busy} !== 2'b11 || memWdata !== 8'h5A || dataRegA !== mA) begin
        nFails++; $display("FAIL mem_stall[%0d]: got v=%b busy=%b d=%h A=%h, required 1 1 5a %h",
                           i, memWvalid, busy, memWdata, dataRegA, mA);
      end
      tick();
    end
    memWready = 1'b1;
    #1;
    nAsserts++;
    if (busy !== 1'b0) begin
      nFails++; $display("FAIL stall_release busy: got %b, required 0", busy);
    end
    tick();
    idleInputs();
    mA = 8'h77;
    nAsserts++;
    if (dataRegA !== mA || memWvalid !== 1'b0) begin
      nFails++; $display("FAIL stall_drain: got A=%h v=%b, required A=%h v=0", dataRegA, memWvalid, mA);
    end
  endtask

  task automatic test_back_to_back();
    memWready = 1'b0;
    wrEn = 1'b1; dst = 2'b11; srcSel = 2'b01; dataIM = 8'h11;
    expQ.push_back(8'h11);
    tick();
    memWready = 1'b1; dataIM = 8'h33;
    expQ.push_back(8'h33);
    #1;
    nAsserts++;
    if (busy !== 1'b0 || memWvalid !== 1'b1) begin
      nFails++; $display("FAIL b2b_accept: got busy=%b v=%b, required 0 1", busy, memWvalid);
    end
    tick();
    idleInputs();
    nAsserts++;
    if (memWvalid !== 1'b1 || memWdata !== 8'h33) begin
      nFails++; $display("FAIL b2b_reload: got v=%b d=%h, required 1 33", memWvalid, memWdata);
    end
    tick();
    nAsserts++;
    if (memWvalid !== 1'b0 || expQ.size() != 0) begin
      nFails++; $display("FAIL b2b_drain: got v=%b pending=%0d, required 0 0", memWvalid, expQ.size());
    end
  endtask

  task automatic test_reset_memw();
    memWready = 1'b0;
    wrEn = 1'b1; dst = 2'b11; srcSel = 2'b00; aluResult = 8'hC3; aluCarry = 1'b1;
    expQ.push_back(8'hC3);
    tick();
    idleInputs();
    nAsserts++;
    if (memWvalid !== 1'b1 || memWdata !== 8'hC3 || {flagZ, flagN, flagC} !== {mZ, mN, mC}) begin
      nFails++; $display("FAIL memw_alu: got v=%b d=%h f=%b, required 1 c3 %b",
                         memWvalid, memWdata, {flagZ, flagN, flagC}, {mZ, mN, mC});
    end
    #3 rst = 1'b1;
    #1;
    expQ.delete();
    mA = 8'h00; mB = 8'h00; mZ = 1'b0; mN = 1'b0; mC = 1'b0;
    nAsserts++;
    if (memWvalid !== 1'b0 || busy !== 1'b0) begin
      nFails++; $display("FAIL memw_reset: got v=%b busy=%b, required 0 0", memWvalid, busy);
    end
    tick();
    rst = 1'b0;
    memWready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nAsserts++;
      if (memWvalid !== 1'b0) begin
        nFails++; $display("FAIL memw_reissue[%0d]: got v=%b, required 0", i, memWvalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_to_a();
    test_async_reset();
    test_imm_to_b();
    test_mem_stall();
    test_back_to_back();
    test_reset_memw();
    nAsserts++;
    if (expQ.size() != 0) begin
      nFails++; $display("FAIL scoreboard_empty: got %0d pending, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
